// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator result display: FSM states,
// active-low seven-segment codes and the double-dabble nibble adjust.
package calc_disp_pkg;

  localparam int DATA_W = 8;
  localparam int BCD_W  = 12;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Index is the decimal digit; bit0 = segment a .. bit6 = segment g.
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam logic [2:0] CNT_LAST = 3'd7;

  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int n = 0; n < BCD_W / 4; n++) begin
      if (adj[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = adj[n*4 +: 4] + 4'd3;
    end
    return adj;
  endfunction

endpackage

// File: rtl/calc_result_display_if.sv
// Result word in, four seven-segment digits plus status out.
interface calc_result_display_if;
  logic [7:0] result_in;
  logic       signed_mode;
  logic [6:0] hex0_n;
  logic [6:0] hex1_n;
  logic [6:0] hex2_n;
  logic [6:0] hex3_n;
  logic       busy;
  logic       update_pulse;

  modport master (
    output result_in, signed_mode,
    input  hex0_n, hex1_n, hex2_n, hex3_n, busy, update_pulse
  );

  modport slave (
    input  result_in, signed_mode,
    output hex0_n, hex1_n, hex2_n, hex3_n, busy, update_pulse
  );
endinterface

// File: rtl/seg7_encode.sv
// Decimal digit to active-low seven-segment code; out-of-range digits show blank.
module seg7_encode
  import calc_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && digit <= 4'd9) seg = SEG_DIGIT[digit];
  end

endmodule

// File: rtl/calc_result_display.sv
// Converts the 8-bit calculator result to sign plus three decimal digits using
// an iterative double-dabble engine; outputs only change on update_pulse.
module calc_result_display
  import calc_disp_pkg::*;
#(
  parameter bit LEADING_ZERO_BLANK = 1'b1,
  parameter bit SEG_ACTIVE_LOW     = 1'b1
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  calc_result_display_if.slave  disp
);

  logic [DATA_W-1:0] res_q;
  logic              mode_q;

  state_t            state, state_nxt;
  logic [2:0]        cnt;
  logic              first;

  logic [DATA_W-1:0] mag;
  logic [BCD_W-1:0]  bcd, bcd_adj;
  logic              neg, neg_load;
  logic [DATA_W-1:0] last_val;
  logic              last_mode;

  logic [6:0]        seg0, seg1, seg2;
  logic              blank1, blank2;
  logic [6:0]        hex0_r, hex1_r, hex2_r, hex3_r;
  logic              pulse_r;

  // Input sampling stage
  always_ff @(posedge clk_clk) begin
    res_q  <= disp.result_in;
    mode_q <= disp.signed_mode;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (first || {mode_q, res_q} != {last_mode, last_val}) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      first   <= 1'b1;
      pulse_r <= 1'b0;
      hex0_r  <= SEG_BLANK;
      hex1_r  <= SEG_BLANK;
      hex2_r  <= SEG_BLANK;
      hex3_r  <= SEG_BLANK;
    end else begin
      state   <= state_nxt;
      pulse_r <= (state == DONE);
      case (state)
        LOAD:  cnt <= 3'd0;
        SHIFT: cnt <= cnt + 3'd1;
        DONE: begin
          first  <= 1'b0;
          hex0_r <= seg0;
          hex1_r <= seg1;
          hex2_r <= seg2;
          hex3_r <= neg ? SEG_MINUS : SEG_BLANK;
        end
        default: ;
      endcase
    end
  end

  assign neg_load = mode_q & res_q[DATA_W-1];
  assign bcd_adj  = bcd_adjust(bcd);

  // Conversion datapath stage; last_val/last_mode record what is on display
  always_ff @(posedge clk_clk) begin
    case (state)
      LOAD: begin
        neg       <= neg_load;
        mag       <= neg_load ? (~res_q + 8'd1) : res_q;
        bcd       <= '0;
        last_val  <= res_q;
        last_mode <= mode_q;
      end
      SHIFT: begin
        bcd <= {bcd_adj[BCD_W-2:0], mag[DATA_W-1]};
        mag <= {mag[DATA_W-2:0], 1'b0};
      end
      default: ;
    endcase
  end

  assign blank2 = LEADING_ZERO_BLANK && (bcd[11:8] == 4'd0);
  assign blank1 = blank2 && (bcd[7:4] == 4'd0);

  seg7_encode u_ones     (.digit(bcd[3:0]),  .blank(1'b0),   .seg(seg0));
  seg7_encode u_tens     (.digit(bcd[7:4]),  .blank(blank1), .seg(seg1));
  seg7_encode u_hundreds (.digit(bcd[11:8]), .blank(blank2), .seg(seg2));

  assign disp.hex0_n       = SEG_ACTIVE_LOW ? hex0_r : ~hex0_r;
  assign disp.hex1_n       = SEG_ACTIVE_LOW ? hex1_r : ~hex1_r;
  assign disp.hex2_n       = SEG_ACTIVE_LOW ? hex2_r : ~hex2_r;
  assign disp.hex3_n       = SEG_ACTIVE_LOW ? hex3_r : ~hex3_r;
  assign disp.busy         = (state != IDLE);
  assign disp.update_pulse = pulse_r;

endmodule

// File: tb/tb_calc_result_display.sv
// Randomised bench for calc_result_display against a decimal-arithmetic model;
// runs one instance with leading-zero blanking and one without.
module tb_calc_result_display;

  localparam logic [6:0] DIG [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_result_display_if ifa ();
  calc_result_display_if ifb ();

  calc_result_display #(.LEADING_ZERO_BLANK(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_dut_a (
    .clk_clk(clk), .reset_reset(rst), .disp(ifa)
  );
  calc_result_display #(.LEADING_ZERO_BLANK(1'b0), .SEG_ACTIVE_LOW(1'b1)) u_dut_b (
    .clk_clk(clk), .reset_reset(rst), .disp(ifb)
  );

  int vectors    = 0;
  int miscompares = 0;
  int pulses_a   = 0;
  int busy_a     = 0;
  logic [7:0] last_v;
  bit         last_m;

  always @(negedge clk) begin
    if (ifa.update_pulse) pulses_a++;
    if (ifa.busy) busy_a++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] model_seg(input logic [7:0] v, input bit m, input int pos,
                                           input bit lzb);
    int val, mg, h, t, o;
    val = m ? int'($signed(v)) : int'(v);
    mg  = (val < 0) ? -val : val;
    h   = mg / 100;
    t   = (mg / 10) % 10;
    o   = mg % 10;
    case (pos)
      0:       return DIG[o];
      1:       return (lzb && h == 0 && t == 0) ? 7'h7F : DIG[t];
      2:       return (lzb && h == 0) ? 7'h7F : DIG[h];
      default: return (val < 0) ? 7'h3F : 7'h7F;
    endcase
  endfunction

  task automatic set_in(input logic [7:0] v, input bit m);
    ifa.result_in = v; ifa.signed_mode = m;
    ifb.result_in = v; ifb.signed_mode = m;
  endtask

  task automatic check_display(input string tag, input logic [7:0] v, input bit m);
    check({tag, "_a_hex0"}, ifa.hex0_n, model_seg(v, m, 0, 1'b1));
    check({tag, "_a_hex1"}, ifa.hex1_n, model_seg(v, m, 1, 1'b1));
    check({tag, "_a_hex2"}, ifa.hex2_n, model_seg(v, m, 2, 1'b1));
    check({tag, "_a_hex3"}, ifa.hex3_n, model_seg(v, m, 3, 1'b1));
    check({tag, "_b_hex0"}, ifb.hex0_n, model_seg(v, m, 0, 1'b0));
    check({tag, "_b_hex1"}, ifb.hex1_n, model_seg(v, m, 1, 1'b0));
    check({tag, "_b_hex2"}, ifb.hex2_n, model_seg(v, m, 2, 1'b0));
    check({tag, "_b_hex3"}, ifb.hex3_n, model_seg(v, m, 3, 1'b0));
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_a_hex0"}, ifa.hex0_n, 7'h7F);
    check({tag, "_a_hex1"}, ifa.hex1_n, 7'h7F);
    check({tag, "_a_hex2"}, ifa.hex2_n, 7'h7F);
    check({tag, "_a_hex3"}, ifa.hex3_n, 7'h7F);
    check({tag, "_a_busy"}, ifa.busy, 1'b0);
    check({tag, "_b_hex1"}, ifb.hex1_n, 7'h7F);
    check({tag, "_b_busy"}, ifb.busy, 1'b0);
  endtask

  // Returns edges from the call until update_pulse is seen, then checks it lasts one cycle.
  task automatic wait_pulse(output int edges);
    edges = 0;
    forever begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (ifa.update_pulse) break;
      if (edges >= 40) begin
        check("pulse_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(negedge clk);
    check("pulse_width", ifa.update_pulse, 1'b0);
  endtask

  task automatic convert(input string tag, input logic [7:0] v, input bit m);
    int e, b0, p0;
    check({tag, "_idle"}, ifa.busy, 1'b0);
    b0 = busy_a;
    p0 = pulses_a;
    set_in(v, m);
    wait_pulse(e);
    check({tag, "_latency"}, e, 12);
    check_display(tag, v, m);
    @(negedge clk);
    #1;
    check({tag, "_busy_cycles"}, busy_a - b0, 10);
    check({tag, "_pulses"}, pulses_a - p0, 1);
    last_v = v;
    last_m = m;
  endtask

  initial begin
    int e, p0;
    logic [7:0] v;
    bit m;

    set_in(8'd0, 1'b0);
    repeat (3) @(negedge clk);
    check_blank("reset");
    check("reset_pulse", ifa.update_pulse, 1'b0);
    rst = 1'b0;
    wait_pulse(e);
    check_display("zero", 8'd0, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    check("zero_pulse_count", pulses_a, 1);
    last_v = 8'd0;
    last_m = 1'b0;

    convert("u255", 8'd255, 1'b0);
    convert("sneg7", 8'hF9, 1'b1);
    convert("sneg128", 8'h80, 1'b1);
    convert("u128", 8'h80, 1'b0);

    // New value arrives during the third SHIFT cycle of the previous one
    p0 = pulses_a;
    set_in(8'd12, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    set_in(8'd34, 1'b0);
    wait_pulse(e);
    check("intr_first_latency", e, 7);
    check_display("intr12", 8'd12, 1'b0);
    repeat (4) @(negedge clk);
    check_display("intr12_hold", 8'd12, 1'b0);
    wait_pulse(e);
    check_display("intr34", 8'd34, 1'b0);
    repeat (15) @(negedge clk);
    #1;
    check("intr_pulses", pulses_a - p0, 2);
    last_v = 8'd34;
    last_m = 1'b0;

    for (int i = 0; i < 20; i++) begin
      v = 8'($urandom_range(0, 255));
      m = 1'($urandom_range(0, 1));
      if (v == last_v && m == last_m) m = ~m;
      convert("rand", v, m);
    end

    // Reset during SHIFT blanks immediately and reconverts afterwards
    set_in(8'd5, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_blank("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_pulse(e);
    check_display("after_reset5", 8'd5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
